// File: rtl/bin_to_seg_display.sv
// Binary to multi-digit 7-segment display driver.
// Converts an unsigned binary value to DIGITS decimal digits with a sequential
// double-dabble FSM (one shift per clock), then registers one active-low
// 7-segment code per digit. Supports leading-zero blanking and overflow dashes.
//
// Ports:
//   i_clk    system clock, all state changes on posedge
//   i_rst_n  asynchronous active-low reset
//   i_bin    binary value, sampled only when i_start is accepted in idle
//   i_start  conversion request, ignored while busy
//   o_busy   high while a conversion is in flight
//   o_done   one-cycle pulse: o_seg / o_ovf just updated
//   o_ovf    last accepted value exceeded 10**DIGITS-1
//   o_seg    active-low {g,f,e,d,c,b,a} per digit; o_seg[6:0] is the units digit
module bin_to_seg_display #(
  parameter int unsigned BIN_W    = 14,
  parameter int unsigned DIGITS   = 4,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [BIN_W-1:0]      i_bin,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_ovf,
  output logic [7*DIGITS-1:0]   o_seg
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(BIN_W + 1);

  localparam logic [6:0] SegBlank = 7'b1111111;
  localparam logic [6:0] SegDash  = 7'b0111111;

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 1;
    for (int unsigned k = 0; k < n; k++) r = r * 10;
    return r;
  endfunction

  localparam longint unsigned MaxVal = pow10(DIGITS) - 1;

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SegDash;
    endcase
    return s;
  endfunction

  typedef enum logic [1:0] {StIdle, StShift, StDecode} state_e;

  state_e               r_state, w_state_next;
  logic [BIN_W-1:0]     r_sh, w_sh_next;
  logic [BcdW-1:0]      r_bcd, w_bcd_next;
  logic [CntW-1:0]      r_cnt, w_cnt_next;
  logic                 r_ovf_nx, w_ovf_nx_next;  // overflow of the conversion in flight
  logic                 r_ovf, w_ovf_next;
  logic                 r_done, w_done_next;
  logic [7*DIGITS-1:0]  r_seg, w_seg_next;

  logic [BcdW-1:0]      w_adj;
  logic [7*DIGITS-1:0]  w_seg;
  logic                 w_seen;
  logic                 w_bin_big;

  assign w_bin_big = (64'(i_bin) > 64'(MaxVal));

  // Double-dabble correction: nibbles >= 5 get +3 before the shift.
  always_comb begin
    w_adj = r_bcd;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (r_bcd[4*d +: 4] >= 4'd5) w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
    end
  end

  // Decode final BCD, scanning from the MSD so blanking stops at the first nonzero digit.
  always_comb begin
    w_seg  = {(7*DIGITS){1'b1}};
    w_seen = 1'b0;
    for (int d = int'(DIGITS) - 1; d >= 0; d--) begin
      if (r_bcd[4*d +: 4] != 4'd0) w_seen = 1'b1;
      if (r_ovf_nx) begin
        w_seg[7*d +: 7] = SegDash;
      end else if (BLANK_LZ && !w_seen && d != 0) begin
        w_seg[7*d +: 7] = SegBlank;
      end else begin
        w_seg[7*d +: 7] = seg7(r_bcd[4*d +: 4]);
      end
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_sh_next     = r_sh;
    w_bcd_next    = r_bcd;
    w_cnt_next    = r_cnt;
    w_ovf_nx_next = r_ovf_nx;
    w_ovf_next    = r_ovf;
    w_seg_next    = r_seg;
    w_done_next   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_sh_next     = i_bin;
          w_bcd_next    = '0;
          w_cnt_next    = '0;
          w_ovf_nx_next = w_bin_big;
          w_state_next  = StShift;
        end
      end
      StShift: begin
        w_sh_next     = {r_sh[BIN_W-2:0], 1'b0};
        w_bcd_next    = {w_adj[BcdW-2:0], r_sh[BIN_W-1]};
        // A carry out of the BCD register only happens for values already flagged;
        // folding it in keeps the flag sticky regardless.
        w_ovf_nx_next = r_ovf_nx | w_adj[BcdW-1];
        w_cnt_next    = r_cnt + CntW'(1);
        if (r_cnt == CntW'(BIN_W - 1)) w_state_next = StDecode;
      end
      StDecode: begin
        w_seg_next   = w_seg;
        w_ovf_next   = r_ovf_nx;
        w_done_next  = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= StIdle;
      r_sh     <= '0;
      r_bcd    <= '0;
      r_cnt    <= '0;
      r_ovf_nx <= 1'b0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
      r_seg    <= {(7*DIGITS){1'b1}};
    end else begin
      r_state  <= w_state_next;
      r_sh     <= w_sh_next;
      r_bcd    <= w_bcd_next;
      r_cnt    <= w_cnt_next;
      r_ovf_nx <= w_ovf_nx_next;
      r_ovf    <= w_ovf_next;
      r_done   <= w_done_next;
      r_seg    <= w_seg_next;
    end
  end

  assign o_busy = (r_state != StIdle);
  assign o_done = r_done;
  assign o_ovf  = r_ovf;
  assign o_seg  = r_seg;

endmodule

// File: tb/tb_bin_to_seg_display.sv
// Scoreboard bench for bin_to_seg_display: one instance with leading-zero
// blanking, one without, driven by the same stimulus.
module tb_bin_to_seg_display;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] DS = 7'b0111111;

  logic        clk;
  logic        rst_n;
  logic [13:0] bin;
  logic        start;
  logic        busy_a, done_a, ovf_a;
  logic        busy_b, done_b, ovf_b;
  logic [27:0] seg_a, seg_b;

  bin_to_seg_display u_dut_a (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_bin   (bin),
    .i_start (start),
    .o_busy  (busy_a),
    .o_done  (done_a),
    .o_ovf   (ovf_a),
    .o_seg   (seg_a)
  );

  bin_to_seg_display #(.BLANK_LZ(1'b0)) u_dut_b (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_bin   (bin),
    .i_start (start),
    .o_busy  (busy_b),
    .o_done  (done_b),
    .o_ovf   (ovf_b),
    .o_seg   (seg_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [27:0] lz;
    logic [27:0] nl;
    logic        ovf;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse consumes one expected result.
  always @(negedge clk) begin
    if (done_a || done_b) begin
      if (q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done actual=%b%b required=00", done_a, done_b);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("done_a", 32'(done_a), 32'd1);
        chk("done_b", 32'(done_b), 32'd1);
        chk("seg_lz", 32'(seg_a), 32'(e.lz));
        chk("seg_nolz", 32'(seg_b), 32'(e.nl));
        chk("ovf_a", 32'(ovf_a), 32'(e.ovf));
        chk("ovf_b", 32'(ovf_b), 32'(e.ovf));
      end
    end
  end

  // Drive a start sampled at the next posedge (edge 0) and record the expected result.
  task automatic issue(input logic [13:0] b, input logic [27:0] e_lz, input logic [27:0] e_nl,
                       input logic e_ovf);
    exp_t e;
    e.lz = e_lz;
    e.nl = e_nl;
    e.ovf = e_ovf;
    q.push_back(e);
    bin   = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count edges until done; busy must stay high until then.
  task automatic wait_done(input string name, input int exp_edges);
    int  k;
    bit  seen;
    bit  busy_drop;
    seen = 0;
    busy_drop = 0;
    k = 0;
    while (!seen && k < 40) begin
      @(posedge clk);
      #1;
      k++;
      if (done_a) seen = 1;
      else if (!busy_a || !busy_b) busy_drop = 1;
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout actual=no_done required=done", name);
    end else begin
      chk({name, "_latency"}, 32'(k), 32'(exp_edges));
      chk({name, "_busy_hold"}, 32'(busy_drop), 32'd0);
      chk({name, "_busy_clear"}, 32'(busy_a), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_seg", 32'(seg_a), 32'h0FFF_FFFF);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_ovf", 32'(ovf_a), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_seg", 32'(seg_a), 32'h0FFF_FFFF);
    chk("idle_busy", 32'(busy_a), 32'd0);

    issue(14'd1023, {S1, S0, S2, S3}, {S1, S0, S2, S3}, 1'b0);
    wait_done("v1023", 15);
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done_a), 32'd0);

    issue(14'd0, {BL, BL, BL, S0}, {S0, S0, S0, S0}, 1'b0);
    wait_done("v0", 15);
    issue(14'd42, {BL, BL, S4, S2}, {S0, S0, S4, S2}, 1'b0);
    wait_done("v42", 15);
    issue(14'd10000, {DS, DS, DS, DS}, {DS, DS, DS, DS}, 1'b1);
    wait_done("v10000", 15);
    issue(14'd9999, {S9, S9, S9, S9}, {S9, S9, S9, S9}, 1'b0);
    wait_done("v9999", 15);

    // Start during busy is dropped; start in the done cycle is accepted.
    issue(14'd7, {BL, BL, BL, S7}, {S0, S0, S0, S7}, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("ignore_busy", 32'(busy_a), 32'd1);
    bin   = 14'd5;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("v7", 10);
    issue(14'd8, {BL, BL, BL, S8}, {S0, S0, S0, S8}, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("seg_hold", 32'(seg_a), 32'({BL, BL, BL, S7}));
    wait_done("v8", 12);

    // Reset mid-conversion: outputs blank immediately, no done.
    bin   = 14'd1234;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_seg_a", 32'(seg_a), 32'h0FFF_FFFF);
    chk("abort_seg_b", 32'(seg_b), 32'h0FFF_FFFF);
    chk("abort_busy", 32'(busy_a), 32'd0);
    chk("abort_done", 32'(done_a), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("abort_no_done_seg", 32'(seg_a), 32'h0FFF_FFFF);

    issue(14'd56, {BL, BL, S5, S6}, {S0, S0, S5, S6}, 1'b0);
    wait_done("v56", 15);
    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
